cpu6_bus_responder: RTL and testbench
=====================================

Name: cpu6_bus_responder

Overview:
- Memory-side target for the CPU6 external bus: decodes `addressBus`, answers read/write cycles from an internal byte RAM, and drives `dataBus` only during read acknowledge.
- Inserts a programmable number of wait states and signals completion with a one-cycle `ready` pulse.
- Sits opposite the CPU6 core on the system bus and is the first real memory model behind it, replacing hard-wired test instruction bytes.

Parameters:
- BASE_ADDR, 16'h0000, first byte address decoded by this block.
- DEPTH, 4096, number of bytes of backing RAM; must be a power of two, ≤ 65536.
- WAIT_STATES, 2, cycles inserted between request capture and `ready`; range 0..15.
- ROM_BASE, 16'hF000, first address of the write-protected region; used only with the optional feature.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- addressBus  input  16  byte address from CPU6.
- dataBus  inout  8  bidirectional data; driven only in ACK of a read, else high-Z.
- read_strobe  input  1  CPU read request; held high until `ready` is seen.
- write_strobe  input  1  CPU write request; write data valid on `dataBus` while high.
- ready  output  1  one-cycle completion pulse.
- bus_error  output  1  one-cycle error pulse, in place of `ready`.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Interface rule (already decided): one clock, `clock`; reset `reset` is synchronous and active-high.
- Reset: state=IDLE; ready=0, bus_error=0, busy=0; dataBus high-Z; wait counter=0. RAM contents are not cleared by reset; simulation initial value is 8'h00.
- Decode: selected when BASE_ADDR ≤ addressBus ≤ BASE_ADDR+DEPTH-1, computed with 17-bit arithmetic so there is no wrap. RAM index = addressBus − BASE_ADDR.
- Unselected addresses: the block stays IDLE, never drives `dataBus`, and never asserts `ready` or `bus_error`.
- State machine (IDLE, WAIT, ACK, RELEASE):
  - IDLE: on an edge with selected address and exactly one strobe high, capture the address and direction (rd/wr).
    - If WAIT_STATES=0, go to ACK; otherwise load counter=WAIT_STATES−1 and go to WAIT.
    - Both strobes high: pulse bus_error next cycle, go to RELEASE, no RAM access.
  - WAIT: decrement the counter; at 0 go to ACK.
    - If the captured strobe drops, abort to IDLE with no access and no pulse.
  - ACK (exactly one cycle):
    - ready=1.
    - Read: dataBus = RAM[captured index], driven for this cycle only.
    - Write: RAM[captured index] <= dataBus, sampled at the ACK edge.
    - Next state is RELEASE.
  - RELEASE: wait until both strobes are low, then go to IDLE. This prevents a held strobe from causing a second access.
- Latency: from the capture edge, `ready` rises WAIT_STATES+1 cycles later.
- Back-to-back: a new request needs at least one cycle with strobes low (RELEASE→IDLE), then is captured on the following edge.
- Address changes after capture are ignored; the captured address is used.
- Reset during WAIT/ACK/RELEASE: IDLE on the next edge, no write committed, dataBus released the same cycle.
- busy=1 in WAIT, ACK, RELEASE.

Optional Feature:
- Macro: CPU6_ROM_PROTECT_EN.
- Defined: writes with captured address ≥ ROM_BASE proceed through WAIT normally. At ACK they assert bus_error instead of ready, and RAM is unchanged. Reads are unaffected.
- Undefined: ROM_BASE is ignored, all selected addresses are writable, and bus_error arises only from simultaneous strobes.

Decomposition:
- Shared package `cpu6_bus_pkg`: state enum (IDLE, WAIT, ACK, RELEASE), bus width constants (ADDR_W=16, DATA_W=8), and the direction encoding.
- One natural sub-module, `cpu6_bus_ram`: single-port synchronous-write, combinational-read byte array of DEPTH entries.
- The FSM, decode and tristate driver stay in the top module.

Test Plan:
- Reset release, WAIT_STATES=2, write 8'hA5 to 16'h0010 → ready high exactly 3 cycles after capture for 1 cycle. A subsequent read of 16'h0010 returns 8'hA5 on dataBus during the ready cycle, and dataBus is high-Z otherwise.
- WAIT_STATES=0, read 16'h0FFF (last byte) → ready 1 cycle after capture. Read 16'h1000 → no ready, no bus_error, dataBus high-Z for 10 cycles.
- read_strobe and write_strobe both high at 16'h0020 → bus_error pulse for 1 cycle, no ready, RAM[0x20] unchanged.
- Strobe held high 5 cycles after ready → exactly one ready pulse. Drop the strobe for 1 cycle, reassert → second ready pulse.
- Write aborted by dropping write_strobe in WAIT, and separately reset asserted in WAIT → no ready, RAM byte keeps its old value, busy=0 the next cycle.
- With CPU6_ROM_PROTECT_EN, BASE_ADDR=16'hE000, DEPTH=8192: write 8'h3C to 16'hF004 → bus_error, no ready, read-back unchanged. Write to 16'hEFFF → ready, read-back 8'h3C.

Source files
------------

// File: rtl/cpu6_bus_pkg.sv
// Shared types and widths for the CPU6 external bus: state encoding, transfer
// direction and the address-window decode helper.
package cpu6_bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK,
        RELEASE
    } bus_state_t;

    typedef enum logic {
        DIR_READ  = 1'b0,
        DIR_WRITE = 1'b1
    } bus_dir_t;

    // One extra bit keeps base+depth-1 from wrapping at the top of the map.
    function automatic logic addr_in_window(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W:0]   depth
    );
        logic [ADDR_W:0] a;
        logic [ADDR_W:0] lo;
        logic [ADDR_W:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + depth - 17'd1;
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/cpu6_bus_ram.sv
// Byte-wide backing store: synchronous write, combinational read, one port.
module cpu6_bus_ram
    import cpu6_bus_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              write_en,
    input  logic [AW-1:0]     index,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data
);

    // Contents survive reset; the declaration value only sets power-up state.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[index] <= write_data;
        end
    end

    assign read_data = mem[index];

endmodule

// File: rtl/cpu6_bus_responder.sv
// CPU6 bus memory target: address decode, wait-state FSM and tristate data driver.
// Define CPU6_ROM_PROTECT_EN to reject writes at or above ROM_BASE with bus_error.
module cpu6_bus_responder
    import cpu6_bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'h0000,
    parameter int                DEPTH       = 4096,
    parameter int                WAIT_STATES = 2,
    parameter logic [ADDR_W-1:0] ROM_BASE    = 16'hF000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addressBus,
    inout  wire  [DATA_W-1:0] dataBus,
    input  logic              read_strobe,
    input  logic              write_strobe,
    output logic              ready,
    output logic              bus_error,
    output logic              busy
);

    localparam int       AW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

`ifdef CPU6_ROM_PROTECT_EN
    localparam bit ROM_PROTECT = 1'b1;
`else
    localparam bit ROM_PROTECT = 1'b0;
`endif

    bus_state_t        state;
    bus_dir_t          cap_dir;
    logic [3:0]        wait_count;
    logic [AW-1:0]     cap_index;
    logic              cap_rom;
    logic              drive_en;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_we;
    logic              selected;
    logic              strobe_held;
    logic              idle_blocked;
    logic              cap_blocked;

    assign selected     = addr_in_window(addressBus, BASE_ADDR, 17'(DEPTH));
    assign strobe_held  = (cap_dir == DIR_WRITE) ? write_strobe : read_strobe;
    assign idle_blocked = ROM_PROTECT && write_strobe && (addressBus >= ROM_BASE);
    assign cap_blocked  = ROM_PROTECT && (cap_dir == DIR_WRITE) && cap_rom;

    // A reset arriving during ACK must not let the pending write land.
    assign ram_we = (state == ACK) && (cap_dir == DIR_WRITE) && !cap_blocked && !reset;

    cpu6_bus_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clock      (clock),
        .write_en   (ram_we),
        .index      (cap_index),
        .write_data (dataBus),
        .read_data  (ram_rdata)
    );

    assign dataBus = (drive_en && !reset) ? ram_rdata : {DATA_W{1'bz}};

    // Outputs are registered alongside the state so each reflects the state it belongs to.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cap_dir    <= DIR_READ;
            wait_count <= 4'd0;
            cap_index  <= '0;
            cap_rom    <= 1'b0;
            ready      <= 1'b0;
            bus_error  <= 1'b0;
            busy       <= 1'b0;
            drive_en   <= 1'b0;
        end else begin
            ready     <= 1'b0;
            bus_error <= 1'b0;
            drive_en  <= 1'b0;
            case (state)
                IDLE: begin
                    if (selected && (read_strobe || write_strobe)) begin
                        cap_index <= AW'(addressBus - BASE_ADDR);
                        cap_dir   <= write_strobe ? DIR_WRITE : DIR_READ;
                        cap_rom   <= (addressBus >= ROM_BASE);
                        busy      <= 1'b1;
                        if (read_strobe && write_strobe) begin
                            bus_error <= 1'b1;
                            state     <= RELEASE;
                        end else if (WAIT_STATES == 0) begin
                            ready     <= !idle_blocked;
                            bus_error <= idle_blocked;
                            drive_en  <= read_strobe;
                            state     <= ACK;
                        end else begin
                            wait_count <= WAIT_LOAD;
                            state      <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!strobe_held) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (wait_count == 4'd0) begin
                        ready     <= !cap_blocked;
                        bus_error <= cap_blocked;
                        drive_en  <= (cap_dir == DIR_READ);
                        state     <= ACK;
                    end else begin
                        wait_count <= wait_count - 4'd1;
                    end
                end
                ACK: begin
                    state <= RELEASE;
                end
                RELEASE: begin
                    // Holding off here keeps a lingering strobe from starting a second access.
                    if (!read_strobe && !write_strobe) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu6_bus_responder.sv
// Directed scoreboard bench for cpu6_bus_responder; the undriven bus is pulled up to 8'hFF.
`timescale 1ns/1ps
module tb_cpu6_bus_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] addr  = 16'h0000;
    logic        rd    = 1'b0;
    logic        wr    = 1'b0;
    logic        drive = 1'b0;
    logic [7:0]  wdata = 8'h00;
    int          sel   = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    wire [7:0] db_main;
    wire [7:0] db_fast;
    logic rdy_main, err_main, busy_main;
    logic rdy_fast, err_fast, busy_fast;
    wire rd_main = rd && (sel == 0);
    wire wr_main = wr && (sel == 0);
    wire rd_fast = rd && (sel == 1);
    wire wr_fast = wr && (sel == 1);

    assign db_main = (drive && sel == 0) ? wdata : 8'hzz;
    assign db_fast = (drive && sel == 1) ? wdata : 8'hzz;

    for (genvar i = 0; i < 8; i++) begin : g_pull
        pullup (db_main[i]);
        pullup (db_fast[i]);
    end

    cpu6_bus_responder #(.BASE_ADDR(16'h0000), .DEPTH(4096), .WAIT_STATES(2)) dut_main (
        .clock(clock), .reset(reset), .addressBus(addr), .dataBus(db_main),
        .read_strobe(rd_main), .write_strobe(wr_main),
        .ready(rdy_main), .bus_error(err_main), .busy(busy_main)
    );

    cpu6_bus_responder #(.BASE_ADDR(16'h0000), .DEPTH(4096), .WAIT_STATES(0)) dut_fast (
        .clock(clock), .reset(reset), .addressBus(addr), .dataBus(db_fast),
        .read_strobe(rd_fast), .write_strobe(wr_fast),
        .ready(rdy_fast), .bus_error(err_fast), .busy(busy_fast)
    );

`ifdef CPU6_ROM_PROTECT_EN
    wire [7:0] db_rom;
    logic rdy_rom, err_rom, busy_rom;
    wire rd_rom = rd && (sel == 2);
    wire wr_rom = wr && (sel == 2);
    assign db_rom = (drive && sel == 2) ? wdata : 8'hzz;
    for (genvar i = 0; i < 8; i++) begin : g_pull_rom
        pullup (db_rom[i]);
    end
    cpu6_bus_responder #(.BASE_ADDR(16'hE000), .DEPTH(8192), .WAIT_STATES(2),
                         .ROM_BASE(16'hF000)) dut_rom (
        .clock(clock), .reset(reset), .addressBus(addr), .dataBus(db_rom),
        .read_strobe(rd_rom), .write_strobe(wr_rom),
        .ready(rdy_rom), .bus_error(err_rom), .busy(busy_rom)
    );
`endif

    logic       obs_ready, obs_err, obs_busy;
    logic [7:0] obs_data;

    always_comb begin
        obs_ready = rdy_main;
        obs_err   = err_main;
        obs_busy  = busy_main;
        obs_data  = db_main;
        case (sel)
            1: begin
                obs_ready = rdy_fast;
                obs_err   = err_fast;
                obs_busy  = busy_fast;
                obs_data  = db_fast;
            end
`ifdef CPU6_ROM_PROTECT_EN
            2: begin
                obs_ready = rdy_rom;
                obs_err   = err_rom;
                obs_busy  = busy_rom;
                obs_data  = db_rom;
            end
`endif
            default: ;
        endcase
    end

    typedef struct {
        logic       is_err;
        logic       check_data;
        logic [7:0] data;
        int         latency;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_output(input int cycles);
        exp_t e;
        check("scoreboard_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({e.tag, ":kind"}, {obs_ready, obs_err}, e.is_err ? 2'b01 : 2'b10);
            check({e.tag, ":latency"}, cycles, e.latency);
            if (e.check_data) check({e.tag, ":data"}, obs_data, e.data);
        end
    endtask

    // Drives one request, waits for its pulse, then holds the strobe 1+hold cycles before dropping it.
    task automatic apply_stimulus(input string tag, input logic [15:0] a, input logic is_rd,
                                  input logic is_wr, input logic [7:0] d, input logic exp_err,
                                  input logic exp_chk, input logic [7:0] exp_data,
                                  input int exp_lat, input int hold);
        int  cycles;
        bit  got;
        exp_t e;
        e.is_err = exp_err; e.check_data = exp_chk; e.data = exp_data;
        e.latency = exp_lat; e.tag = tag;
        addr = a; rd = is_rd; wr = is_wr; wdata = d; drive = is_wr;
        exp_q.push_back(e);
        got = 0;
        cycles = 0;
        while (!got && cycles < 20) begin
            tick();
            cycles++;
            if (obs_ready || obs_err) got = 1;
            else if (!drive) check({tag, ":z_before"}, obs_data, 8'hFF);
        end
        check({tag, ":response"}, got, 1'b1);
        if (got) check_output(cycles);
        else void'(exp_q.pop_front());
        for (int i = 0; i <= hold; i++) begin
            tick();
            check({tag, ":single_pulse"}, {obs_ready, obs_err}, 2'b00);
            if (!drive) check({tag, ":z_after"}, obs_data, 8'hFF);
        end
        rd = 0; wr = 0; drive = 0;
        tick();
        check({tag, ":idle"}, obs_busy, 1'b0);
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] start");
        repeat (3) tick();
        check("reset:ready", rdy_main, 1'b0);
        check("reset:bus_error", err_main, 1'b0);
        check("reset:busy", busy_main, 1'b0);
        check("reset:data_z", db_main, 8'hFF);
        check("reset:fast_busy", busy_fast, 1'b0);
        reset = 0;
        tick();

        sel = 0;
        apply_stimulus("wr_0010", 16'h0010, 0, 1, 8'hA5, 0, 0, 8'h00, 3, 0);
        apply_stimulus("rd_0010", 16'h0010, 1, 0, 8'h00, 0, 1, 8'hA5, 3, 0);

        // Strobe held well past ready must not retrigger; a one-cycle drop allows the next access.
        apply_stimulus("held_rd", 16'h0010, 1, 0, 8'h00, 0, 1, 8'hA5, 3, 4);
        apply_stimulus("held_rd2", 16'h0010, 1, 0, 8'h00, 0, 1, 8'hA5, 3, 0);

        apply_stimulus("wr_0020", 16'h0020, 0, 1, 8'h42, 0, 0, 8'h00, 3, 0);
        apply_stimulus("both_0020", 16'h0020, 1, 1, 8'hEE, 1, 0, 8'h00, 1, 0);
        apply_stimulus("rd_0020", 16'h0020, 1, 0, 8'h00, 0, 1, 8'h42, 3, 0);

        apply_stimulus("wr_0030", 16'h0030, 0, 1, 8'h11, 0, 0, 8'h00, 3, 0);
        addr = 16'h0030; wr = 1; wdata = 8'h55; drive = 1;
        tick();
        check("abort:busy_wait", busy_main, 1'b1);
        tick();
        wr = 0; drive = 0;
        tick();
        check("abort:busy", busy_main, 1'b0);
        check("abort:ready", {rdy_main, err_main}, 2'b00);
        tick();
        apply_stimulus("rd_after_abort", 16'h0030, 1, 0, 8'h00, 0, 1, 8'h11, 3, 0);

        addr = 16'h0030; wr = 1; wdata = 8'h77; drive = 1;
        tick();
        reset = 1;
        tick();
        check("rst_wait:busy", busy_main, 1'b0);
        check("rst_wait:ready", {rdy_main, err_main}, 2'b00);
        reset = 0; wr = 0; drive = 0;
        tick();
        apply_stimulus("rd_after_reset", 16'h0030, 1, 0, 8'h00, 0, 1, 8'h11, 3, 0);

        sel = 1;
        apply_stimulus("fast_wr_0fff", 16'h0FFF, 0, 1, 8'h5A, 0, 0, 8'h00, 1, 0);
        apply_stimulus("fast_rd_0fff", 16'h0FFF, 1, 0, 8'h00, 0, 1, 8'h5A, 1, 0);
        addr = 16'h1000; rd = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("unsel:pulses", {obs_ready, obs_err}, 2'b00);
            check("unsel:data_z", obs_data, 8'hFF);
            check("unsel:busy", obs_busy, 1'b0);
        end
        rd = 0;
        tick();

`ifdef CPU6_ROM_PROTECT_EN
        sel = 2;
        apply_stimulus("rom_wr_f004", 16'hF004, 0, 1, 8'h3C, 1, 0, 8'h00, 3, 0);
        apply_stimulus("rom_rd_f004", 16'hF004, 1, 0, 8'h00, 0, 1, 8'h00, 3, 0);
        apply_stimulus("ram_wr_efff", 16'hEFFF, 0, 1, 8'h3C, 0, 0, 8'h00, 3, 0);
        apply_stimulus("ram_rd_efff", 16'hEFFF, 1, 0, 8'h00, 0, 1, 8'h3C, 3, 0);
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
